// File: rtl/sub_bytes_pkg.sv
// rtl/sub_bytes_pkg.sv - shared widths, table type and AES forward S-box constant for sub_bytes
`ifndef SBOX_WIDTH
`define SBOX_WIDTH 16
`endif
`ifndef SBOX_HEIGHT
`define SBOX_HEIGHT 16
`endif
`ifndef WORD_DATA_WIDTH
`define WORD_DATA_WIDTH 32
`endif

package sub_bytes_pkg;

    localparam int SBOX_ENTRIES   = `SBOX_WIDTH * `SBOX_HEIGHT;
    localparam int BYTES_PER_WORD = `WORD_DATA_WIDTH / 8;

    typedef logic [7:0] sbox_table_t [SBOX_ENTRIES];

    localparam sbox_table_t AES_SBOX = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sub_bytes_if.sv
// rtl/sub_bytes_if.sv - table load and dual-client substitution signals of sub_bytes
interface sub_bytes_if #(
    parameter int WORD_W  = `WORD_DATA_WIDTH,
    parameter int TABLE_W = `SBOX_WIDTH * `SBOX_HEIGHT * 8
);
    logic               sbox_in_vld;
    logic [TABLE_W-1:0] sbox_in;
    logic [WORD_W-1:0]  key_exp_val;
    logic               key_exp_val_vld;
    logic [WORD_W-1:0]  sub_bytes_val;
    logic               sub_bytes_val_vld;
    logic [WORD_W-1:0]  key_exp_sbox_data;
    logic               key_exp_sbox_data_vld;
    logic [WORD_W-1:0]  sub_bytes_sbox_data;
    logic               sub_bytes_sbox_data_vld;
    logic               sbox_available;

    modport master (
        output sbox_in_vld, sbox_in, key_exp_val, key_exp_val_vld, sub_bytes_val, sub_bytes_val_vld,
        input  key_exp_sbox_data, key_exp_sbox_data_vld, sub_bytes_sbox_data, sub_bytes_sbox_data_vld,
               sbox_available
    );

    modport slave (
        input  sbox_in_vld, sbox_in, key_exp_val, key_exp_val_vld, sub_bytes_val, sub_bytes_val_vld,
        output key_exp_sbox_data, key_exp_sbox_data_vld, sub_bytes_sbox_data, sub_bytes_sbox_data_vld,
               sbox_available
    );
endinterface

// File: rtl/sub_bytes_sbox_word_lookup.sv
// rtl/sub_bytes_sbox_word_lookup.sv - combinational byte-wise table substitution of one word
module sbox_word_lookup
    import sub_bytes_pkg::*;
#(
    parameter int WORD_W = `WORD_DATA_WIDTH
) (
    input  sbox_table_t       sbox_table,
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);
    always_comb begin
        word_out = '0;
        for (int i = 0; i < WORD_W / 8; i++) begin
            word_out[8*i +: 8] = sbox_table[word_in[8*i +: 8]];
        end
    end
endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - shared AES S-box with two registered word clients (key expansion, round datapath)
// Build option SUB_BYTES_ROM_EN: fixed AES forward S-box ROM instead of the loadable table.
module sub_bytes
    import sub_bytes_pkg::*;
#(
    parameter int SBOX_W = `SBOX_WIDTH,
    parameter int SBOX_H = `SBOX_HEIGHT,
    parameter int WORD_W = `WORD_DATA_WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    sub_bytes_if.slave  bus
);
    sbox_table_t       table_q;
    logic              loaded_q;
    logic [WORD_W-1:0] key_lookup;
    logic [WORD_W-1:0] sb_lookup;
    logic [WORD_W-1:0] key_data_q;
    logic [WORD_W-1:0] sb_data_q;
    logic              key_vld_q;
    logic              sb_vld_q;

`ifdef SUB_BYTES_ROM_EN
    assign table_q = AES_SBOX;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loaded_q <= 1'b0;
        end else begin
            loaded_q <= 1'b1;
        end
    end
`else
    // Lookups below read table_q before this edge's capture, so a request
    // coinciding with a reload still sees the old table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SBOX_W * SBOX_H; k++) begin
                table_q[k] <= '0;
            end
            loaded_q <= 1'b0;
        end else if (bus.sbox_in_vld) begin
            for (int k = 0; k < SBOX_W * SBOX_H; k++) begin
                table_q[k] <= bus.sbox_in[8*k +: 8];
            end
            loaded_q <= 1'b1;
        end
    end
`endif

    sbox_word_lookup #(.WORD_W(WORD_W)) u_key_lookup (
        .sbox_table (table_q),
        .word_in    (bus.key_exp_val),
        .word_out   (key_lookup)
    );

    sbox_word_lookup #(.WORD_W(WORD_W)) u_sb_lookup (
        .sbox_table (table_q),
        .word_in    (bus.sub_bytes_val),
        .word_out   (sb_lookup)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_vld_q  <= 1'b0;
            sb_vld_q   <= 1'b0;
            key_data_q <= '0;
            sb_data_q  <= '0;
        end else begin
            key_vld_q <= bus.key_exp_val_vld & loaded_q;
            sb_vld_q  <= bus.sub_bytes_val_vld & loaded_q;
            if (bus.key_exp_val_vld && loaded_q) begin
                key_data_q <= key_lookup;
            end
            if (bus.sub_bytes_val_vld && loaded_q) begin
                sb_data_q <= sb_lookup;
            end
        end
    end

    assign bus.key_exp_sbox_data       = key_data_q;
    assign bus.key_exp_sbox_data_vld   = key_vld_q;
    assign bus.sub_bytes_sbox_data     = sb_data_q;
    assign bus.sub_bytes_sbox_data_vld = sb_vld_q;
    assign bus.sbox_available          = loaded_q;
endmodule

// File: tb/tb_sub_bytes.sv
// tb/tb_sub_bytes.sv - directed scoreboard bench for sub_bytes
module tb_sub_bytes;
    logic clock = 1'b0;
    logic reset = 1'b1;

    sub_bytes_if bus ();

    sub_bytes dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] key_q [$];
    logic [31:0] sb_q  [$];
    logic [31:0] last_key  = '0;
    logic [31:0] last_sb   = '0;
    logic        exp_avail = 1'b0;

    logic [2047:0] aes_img;
    logic [2047:0] id_img;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8), then the AES affine map.
    function automatic logic [7:0] aes_s(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic kv;
        logic sv;
        kv = (key_q.size() > 0);
        sv = (sb_q.size() > 0);
        if (kv) last_key = key_q.pop_front();
        if (sv) last_sb  = sb_q.pop_front();
        chk({tag, "/key_vld"}, 32'(bus.key_exp_sbox_data_vld), 32'(kv));
        chk({tag, "/key_data"}, bus.key_exp_sbox_data, last_key);
        chk({tag, "/sb_vld"}, 32'(bus.sub_bytes_sbox_data_vld), 32'(sv));
        chk({tag, "/sb_data"}, bus.sub_bytes_sbox_data, last_sb);
        chk({tag, "/avail"}, 32'(bus.sbox_available), 32'(exp_avail));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.key_exp_val_vld   = 1'b0;
        bus.sub_bytes_val_vld = 1'b0;
        bus.sbox_in_vld       = 1'b0;
    endtask

    task automatic req_key(input logic [31:0] w, input logic [31:0] exp, input bit push);
        bus.key_exp_val     = w;
        bus.key_exp_val_vld = 1'b1;
        if (push) key_q.push_back(exp);
    endtask

    task automatic req_sb(input logic [31:0] w, input logic [31:0] exp, input bit push);
        bus.sub_bytes_val     = w;
        bus.sub_bytes_val_vld = 1'b1;
        if (push) sb_q.push_back(exp);
    endtask

    task automatic load(input logic [2047:0] img);
        bus.sbox_in     = img;
        bus.sbox_in_vld = 1'b1;
    endtask

    initial begin
        bus.sbox_in_vld       = 1'b0;
        bus.sbox_in           = '0;
        bus.key_exp_val       = '0;
        bus.key_exp_val_vld   = 1'b0;
        bus.sub_bytes_val     = '0;
        bus.sub_bytes_val_vld = 1'b0;
        for (int k = 0; k < 256; k++) begin
            aes_img[8*k +: 8] = aes_s(8'(k));
            id_img[8*k +: 8]  = 8'(k);
        end

        repeat (2) @(posedge clock);
        #1;
        check_all("in_reset");
        @(negedge clock);
        reset = 1'b0;

        req_key(32'hDEADBEEF, 32'h0, 1'b0);
        tick();
        check_all("drop_unloaded");

        load(aes_img);
        tick();
        exp_avail = 1'b1;
        check_all("load_aes");

        req_sb(32'h000153FF, 32'h637CED16, 1'b1);
        tick();
        check_all("sb_first");
        tick();
        check_all("sb_hold");

        req_key(32'hCF4F3C09, 32'h8A84EB01, 1'b1);
        req_sb(32'h00000000, 32'h63636363, 1'b1);
        tick();
        check_all("dual");

        req_sb(32'h01010101, 32'h7C7C7C7C, 1'b1);
        tick();
        check_all("b2b_0");
        req_sb(32'hFFFFFFFF, 32'h16161616, 1'b1);
        tick();
        check_all("b2b_1");
        tick();
        check_all("b2b_idle");

        load(id_img);
        tick();
        check_all("load_id");
        req_sb(32'hA5C3007E, 32'hA5C3007E, 1'b1);
        tick();
        check_all("identity");

        load(aes_img);
        req_sb(32'h00000000, 32'h00000000, 1'b1);
        tick();
        check_all("reload_old");
        req_sb(32'h00000000, 32'h63636363, 1'b1);
        tick();
        check_all("reload_new");

        req_key(32'h01010101, 32'h7C7C7C7C, 1'b1);
        req_sb(32'h000153FF, 32'h637CED16, 1'b1);
        tick();
        check_all("stream");
        req_key(32'hFFFFFFFF, 32'h0, 1'b0);
        req_sb(32'h01010101, 32'h0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        exp_avail = 1'b0;
        last_key  = '0;
        last_sb   = '0;
        key_q.delete();
        sb_q.delete();
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        tick();
        check_all("post_rst_drop");

        load(aes_img);
        tick();
        exp_avail = 1'b1;
        check_all("post_rst_load");
        req_key(32'h00000000, 32'h63636363, 1'b1);
        tick();
        check_all("post_rst_req");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
